// File: rtl/hop_scan_io_pkg.sv
// Shared definitions for the hop-code scan / front-panel GPIO block.
//   - GPIO bit positions of the scan signals
//   - default GPIO masks and direction register
//   - scan sequencer state encoding
package hop_scan_io_pkg;

  localparam int unsigned GPIO_W = 12;

  // Front-panel GPIO positions of the scan-chain signals
  localparam logic [GPIO_W-1:0] SCAN_ID_BIT      = 12'h400;
  localparam logic [GPIO_W-1:0] SCAN_PHI_BIT     = 12'h100;
  localparam logic [GPIO_W-1:0] SCAN_PHI_BAR_BIT = 12'h040;
  localparam logic [GPIO_W-1:0] SCAN_DATA_BIT    = 12'h010;
  localparam logic [GPIO_W-1:0] SCAN_LOAD_BIT    = 12'h004;

  localparam logic [GPIO_W-1:0] DEF_OUT_MASK = 12'hD55;
  localparam logic [GPIO_W-1:0] DEF_IN_MASK  = 12'h022;
  localparam logic [GPIO_W-1:0] DEF_IO_DDR   = 12'hD55;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PHI     = 3'd1,
    ST_PHI_BAR = 3'd2,
    ST_LOAD    = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_e;

endpackage

// File: rtl/hop_scan_io_clk_strobe_div.sv
// Clock divider producing a 50% duty toggle and a one-cycle strobe that
// coincides with each rising toggle. Nothing is clocked by div_clk_o.
//   clk       in   system clock
//   rst_n     in   async active-low reset
//   div_clk_o out  divided clock, period DIV_FAC clk cycles
//   strobe_o  out  1-cycle pulse, high in the first cycle div_clk_o is high
module hop_scan_io_clk_strobe_div #(
  parameter int unsigned DIV_FAC = 20
) (
  input  logic clk,
  input  logic rst_n,
  output logic div_clk_o,
  output logic strobe_o
);

  localparam int unsigned HALF = DIV_FAC / 2;
  localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q;
  logic          div_clk_q;
  logic          strobe_q;

  // Half-period counter; toggle at terminal count, strobe on the rising toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_clk_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (cnt_q == CW'(HALF - 1)) begin
        cnt_q     <= '0;
        div_clk_q <= ~div_clk_q;
        strobe_q  <= ~div_clk_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign div_clk_o = div_clk_q;
  assign strobe_o  = strobe_q;

endmodule

// File: rtl/hop_scan_io.sv
// Hop-code scan-chain driver plus front-panel GPIO register.
// Shifts NTX_BITS of data_in MSB-first into the tag chip with a two-phase
// phi/phi_bar protocol, pulses load, then holds done until srst/reset. The
// scan signals, OR'd with user bits, are presented on a masked GPIO register
// updated every GPIO_CLK_DIV_FAC cycles.
//   clk, reset     system clock, async active-low reset
//   srst           sync restart of the scan sequence
//   data_in        hop code, low NTX_BITS used
//   user_gpio_out  extra GPIO output bits
//   fp_gpio_in     pin inputs (asynchronous)
//   fp_gpio_out    registered pin outputs
//   fp_gpio_ddr    pin direction, constant
//   gpio_in        synchronised, masked pin inputs
//   scan_clk       divided scan clock
//   nbits_cnt      bits fully shifted
//   scan_done      load phase complete
module hop_scan_io
  import hop_scan_io_pkg::*;
#(
  parameter int unsigned SCAN_CLK_DIV_FAC = 20,
  parameter int unsigned SCAN_WIDTH       = 2,
  parameter int unsigned NTX_BITS         = 78,
  parameter int unsigned TX_BITS_WIDTH    = 128,
  parameter int unsigned BIT_CNT_WIDTH    = 7,
  parameter int unsigned GPIO_REG_WIDTH   = 12,
  parameter int unsigned GPIO_CLK_DIV_FAC = 10,
  parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK = GPIO_REG_WIDTH'(DEF_OUT_MASK),
  parameter logic [GPIO_REG_WIDTH-1:0] IN_MASK  = GPIO_REG_WIDTH'(DEF_IN_MASK),
  parameter logic [GPIO_REG_WIDTH-1:0] IO_DDR   = GPIO_REG_WIDTH'(DEF_IO_DDR)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      srst,
  input  logic [TX_BITS_WIDTH-1:0]  data_in,
  input  logic [GPIO_REG_WIDTH-1:0] user_gpio_out,
  input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
  output logic [GPIO_REG_WIDTH-1:0] gpio_in,
  output logic                      scan_clk,
  output logic [BIT_CNT_WIDTH-1:0]  nbits_cnt,
  output logic                      scan_done
);

  localparam int unsigned PW = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;

  logic scan_tick;
  logic gpio_tick;
  logic gpio_clk_unused;
  logic data_in_unused;

  scan_state_e               state_q;
  logic [PW-1:0]             phase_q;
  logic [NTX_BITS-1:0]       shift_q;
  logic [BIT_CNT_WIDTH-1:0]  nbits_cnt_q;
  logic                      scan_done_q;
  logic                      scan_id_q;
  logic                      scan_phi_q;
  logic                      scan_phi_bar_q;
  logic                      scan_load_q;
  logic                      scan_data_c;

  logic [GPIO_REG_WIDTH-1:0] sync1_q;
  logic [GPIO_REG_WIDTH-1:0] sync2_q;
  logic [GPIO_REG_WIDTH-1:0] fp_gpio_out_q;
  logic [GPIO_REG_WIDTH-1:0] gpio_in_q;
  logic [GPIO_REG_WIDTH-1:0] gpio_word_c;

  // Bits above NTX_BITS are ignored by design
  assign data_in_unused = ^data_in;

  hop_scan_io_clk_strobe_div #(.DIV_FAC(SCAN_CLK_DIV_FAC)) u_scan_div (
    .clk       (clk),
    .rst_n     (reset),
    .div_clk_o (scan_clk),
    .strobe_o  (scan_tick)
  );

  hop_scan_io_clk_strobe_div #(.DIV_FAC(GPIO_CLK_DIV_FAC)) u_gpio_div (
    .clk       (clk),
    .rst_n     (reset),
    .div_clk_o (gpio_clk_unused),
    .strobe_o  (gpio_tick)
  );

  // Scan sequencer; advances only on scan_tick, srst has priority over tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      shift_q        <= '0;
      nbits_cnt_q    <= '0;
      scan_done_q    <= 1'b0;
      scan_id_q      <= 1'b0;
      scan_phi_q     <= 1'b0;
      scan_phi_bar_q <= 1'b0;
      scan_load_q    <= 1'b0;
    end else if (srst) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      nbits_cnt_q    <= '0;
      scan_done_q    <= 1'b0;
      scan_id_q      <= 1'b0;
      scan_phi_q     <= 1'b0;
      scan_phi_bar_q <= 1'b0;
      scan_load_q    <= 1'b0;
    end else if (scan_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          shift_q    <= data_in[NTX_BITS-1:0];
          phase_q    <= '0;
          scan_id_q  <= 1'b1;
          scan_phi_q <= 1'b1;
          state_q    <= ST_PHI;
        end
        ST_PHI: begin
          if (phase_q == PW'(SCAN_WIDTH - 1)) begin
            phase_q        <= '0;
            scan_phi_q     <= 1'b0;
            scan_phi_bar_q <= 1'b1;
            state_q        <= ST_PHI_BAR;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        ST_PHI_BAR: begin
          if (phase_q == PW'(SCAN_WIDTH - 1)) begin
            phase_q        <= '0;
            scan_phi_bar_q <= 1'b0;
            shift_q        <= {shift_q[NTX_BITS-2:0], 1'b0};
            if (nbits_cnt_q != BIT_CNT_WIDTH'(NTX_BITS)) begin
              nbits_cnt_q <= nbits_cnt_q + BIT_CNT_WIDTH'(1);
            end
            if (nbits_cnt_q >= BIT_CNT_WIDTH'(NTX_BITS - 1)) begin
              scan_load_q <= 1'b1;
              state_q     <= ST_LOAD;
            end else begin
              scan_phi_q <= 1'b1;
              state_q    <= ST_PHI;
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        ST_LOAD: begin
          if (phase_q == PW'(SCAN_WIDTH - 1)) begin
            phase_q     <= '0;
            scan_load_q <= 1'b0;
            scan_id_q   <= 1'b0;
            scan_done_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Data is the shift-register MSB, only presented during phi/phi_bar
  assign scan_data_c = shift_q[NTX_BITS-1] & (scan_phi_q | scan_phi_bar_q);

  // Scan signals mapped onto their GPIO positions, merged with user bits
  always_comb begin
    gpio_word_c = user_gpio_out;
    if (scan_id_q)      gpio_word_c = gpio_word_c | GPIO_REG_WIDTH'(SCAN_ID_BIT);
    if (scan_phi_q)     gpio_word_c = gpio_word_c | GPIO_REG_WIDTH'(SCAN_PHI_BIT);
    if (scan_phi_bar_q) gpio_word_c = gpio_word_c | GPIO_REG_WIDTH'(SCAN_PHI_BAR_BIT);
    if (scan_data_c)    gpio_word_c = gpio_word_c | GPIO_REG_WIDTH'(SCAN_DATA_BIT);
    if (scan_load_q)    gpio_word_c = gpio_word_c | GPIO_REG_WIDTH'(SCAN_LOAD_BIT);
  end

  // Pin synchroniser every cycle; GPIO registers refresh on the GPIO strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      fp_gpio_out_q <= '0;
      gpio_in_q     <= '0;
    end else begin
      sync1_q <= fp_gpio_in;
      sync2_q <= sync1_q;
      if (gpio_tick) begin
        fp_gpio_out_q <= gpio_word_c & OUT_MASK;
        gpio_in_q     <= sync2_q & IN_MASK;
      end
    end
  end

  assign fp_gpio_out = fp_gpio_out_q;
  assign gpio_in     = gpio_in_q;
  assign fp_gpio_ddr = IO_DDR;
  assign nbits_cnt   = nbits_cnt_q;
  assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_hop_scan_io.sv
// Directed bench for hop_scan_io: reset values, scan clock shape, GPIO
// mapping table, synchroniser/strobe timing, full scan sequences, srst
// mid-shift and asynchronous reset during load.
module tb_hop_scan_io;

  logic         clk = 1'b0;
  logic         reset;
  logic         srst;
  logic [127:0] data_in;
  logic [11:0]  user_gpio_out;
  logic [11:0]  fp_gpio_in;
  logic [11:0]  fp_gpio_out;
  logic [11:0]  fp_gpio_ddr;
  logic [11:0]  gpio_in;
  logic         scan_clk;
  logic [6:0]   nbits_cnt;
  logic         scan_done;

  int n_tests = 0;
  int n_fail  = 0;

  hop_scan_io dut (
    .clk           (clk),
    .reset         (reset),
    .srst          (srst),
    .data_in       (data_in),
    .user_gpio_out (user_gpio_out),
    .fp_gpio_in    (fp_gpio_in),
    .fp_gpio_out   (fp_gpio_out),
    .fp_gpio_ddr   (fp_gpio_ddr),
    .gpio_in       (gpio_in),
    .scan_clk      (scan_clk),
    .nbits_cnt     (nbits_cnt),
    .scan_done     (scan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] user;
    logic [11:0] pin;
    logic [11:0] exp_out;
    logic [11:0] exp_in;
  } gvec_t;

  gvec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drop srst while scan_clk is low so the next tick is unambiguously seen
  task automatic release_srst();
    int guard;
    guard = 0;
    while (scan_clk && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    srst = 1'b0;
  endtask

  // Watch one full sequence from IDLE through DONE via the GPIO pins
  task automatic run_scan(input logic [127:0] d, input string tag);
    int rises, ticks, phi_p, phib_p, ovl, iderr, derr, dmis;
    int phi_c, phib_c, load_c, id_c, mono, cyc, extra;
    logic prev_clk, cur_bit, done_seen;
    logic [11:0] prev_g, g;
    logic [6:0] prev_n;
    logic rec [78];
    rises = 0; ticks = 0; phi_p = 0; phib_p = 0; ovl = 0; iderr = 0;
    derr = 0; dmis = 0; phi_c = 0; phib_c = 0; load_c = 0; id_c = 0;
    mono = 0; cyc = 0; extra = 0; cur_bit = 1'b0; done_seen = 1'b0;
    for (int k = 0; k < 78; k++) rec[k] = 1'b0;
    prev_clk = scan_clk;
    prev_g   = fp_gpio_out;
    prev_n   = nbits_cnt;
    while (cyc < 8000 && !(done_seen && extra >= 30)) begin
      @(negedge clk);
      cyc++;
      g = fp_gpio_out;
      if (scan_clk && !prev_clk) rises++;
      prev_clk = scan_clk;
      if (g[8] && g[6]) ovl++;
      if ((g[8] || g[6] || g[2]) && !g[10]) iderr++;
      if (g[8] && !prev_g[8]) begin
        if (phi_p < 78) rec[phi_p] = g[4];
        cur_bit = g[4];
        phi_p++;
      end
      if (g[6] && !prev_g[6]) phib_p++;
      if ((g[8] || g[6]) && g[4] !== cur_bit) derr++;
      if (g[8])  phi_c++;
      if (g[6])  phib_c++;
      if (g[2])  load_c++;
      if (g[10]) id_c++;
      if (nbits_cnt != prev_n && nbits_cnt != prev_n + 7'd1) mono++;
      prev_n = nbits_cnt;
      prev_g = g;
      if (scan_done && !done_seen) begin
        done_seen = 1'b1;
        ticks = rises;
      end
      if (done_seen) extra++;
    end
    if (!done_seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: scan_done not seen after %0d cycles", tag, cyc);
    end
    for (int k = 0; k < 78; k++) if (rec[k] !== d[77-k]) dmis++;
    check({tag, "_ticks"},      32'(ticks),  32'd315);
    check({tag, "_nbits"},      32'(nbits_cnt), 32'd78);
    check({tag, "_phi_pulses"}, 32'(phi_p),  32'd78);
    check({tag, "_phib_pulses"},32'(phib_p), 32'd78);
    check({tag, "_overlap"},    32'(ovl),    32'd0);
    check({tag, "_id_gaps"},    32'(iderr),  32'd0);
    check({tag, "_data_stable"},32'(derr),   32'd0);
    check({tag, "_data_order"}, 32'(dmis),   32'd0);
    check({tag, "_phi_clks"},   32'(phi_c),  32'd3120);
    check({tag, "_phib_clks"},  32'(phib_c), 32'd3120);
    check({tag, "_load_clks"},  32'(load_c), 32'd40);
    check({tag, "_id_clks"},    32'(id_c),   32'd6280);
    check({tag, "_nbits_mono"}, 32'(mono),   32'd0);
    check({tag, "_gpio_idle"},  32'(fp_gpio_out), 32'h000);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] data_a, data_b;
    int hi, lo, n, guard;

    vecs[0] = '{user: 12'hFFF, pin: 12'hFFF, exp_out: 12'hD55, exp_in: 12'h022};
    vecs[1] = '{user: 12'h000, pin: 12'h000, exp_out: 12'h000, exp_in: 12'h000};
    vecs[2] = '{user: 12'h123, pin: 12'h0F0, exp_out: 12'h101, exp_in: 12'h020};
    vecs[3] = '{user: 12'hA5A, pin: 12'h002, exp_out: 12'h850, exp_in: 12'h002};
    vecs[4] = '{user: 12'h555, pin: 12'hFDD, exp_out: 12'h555, exp_in: 12'h000};

    data_a = '0;
    data_b = '1;
    for (int i = 0; i < 78; i++) begin
      data_a[i] = (i % 2 == 1);
      data_b[i] = (i % 3 == 0);
    end

    // Reset state, with active pin inputs to show they are not sampled
    reset = 1'b0; srst = 1'b0; data_in = data_a;
    user_gpio_out = 12'hFFF; fp_gpio_in = 12'hFFF;
    repeat (5) @(negedge clk);
    check("rst_fp_gpio_out", 32'(fp_gpio_out), 32'h000);
    check("rst_gpio_in",     32'(gpio_in),     32'h000);
    check("rst_ddr",         32'(fp_gpio_ddr), 32'hD55);
    check("rst_scan_done",   32'(scan_done),   32'd0);
    check("rst_nbits",       32'(nbits_cnt),   32'd0);
    check("rst_scan_clk",    32'(scan_clk),    32'd0);

    // Scan clock shape, FSM parked by srst
    srst = 1'b1; reset = 1'b1;
    guard = 0;
    while (!scan_clk && guard < 50) begin @(negedge clk); guard++; end
    hi = 0;
    while (scan_clk && hi < 50) begin hi++; @(negedge clk); end
    lo = 0;
    while (!scan_clk && lo < 50) begin lo++; @(negedge clk); end
    check("scan_clk_high", 32'(hi), 32'd10);
    check("scan_clk_low",  32'(lo), 32'd10);

    // GPIO mapping table
    for (int v = 0; v < 5; v++) begin
      user_gpio_out = vecs[v].user;
      fp_gpio_in    = vecs[v].pin;
      repeat (25) @(negedge clk);
      check($sformatf("gpio_out_v%0d", v), 32'(fp_gpio_out), 32'(vecs[v].exp_out));
      check($sformatf("gpio_in_v%0d",  v), 32'(gpio_in),     32'(vecs[v].exp_in));
    end

    // Synchroniser latency: at least 3, at most 12 cycles
    fp_gpio_in = 12'h000;
    repeat (25) @(negedge clk);
    fp_gpio_in = 12'hFFF;
    n = 0;
    while (gpio_in !== 12'h022 && n < 20) begin @(negedge clk); n++; end
    check("sync_latency_max", 32'(n <= 12), 32'd1);
    check("sync_latency_min", 32'(n >= 3),  32'd1);

    // Output refresh only on the 10-cycle strobe
    user_gpio_out = 12'h001;
    n = 0;
    while (fp_gpio_out !== 12'h001 && n < 20) begin @(negedge clk); n++; end
    user_gpio_out = 12'h004;
    n = 0;
    while (fp_gpio_out !== 12'h004 && n < 30) begin @(negedge clk); n++; end
    check("gpio_strobe_period", 32'(n), 32'd10);

    // Full scan, alternating pattern
    user_gpio_out = 12'h000; fp_gpio_in = 12'h000; data_in = data_a;
    repeat (12) @(negedge clk);
    release_srst();
    run_scan(data_a, "scanA");
    repeat (100) @(negedge clk);
    check("done_hold",  32'(scan_done), 32'd1);
    check("nbits_hold", 32'(nbits_cnt), 32'd78);

    // srst at nbits_cnt=40 restarts with freshly latched data
    srst = 1'b1;
    repeat (2) @(negedge clk);
    release_srst();
    guard = 0;
    while (nbits_cnt != 7'd40 && guard < 5000) begin @(negedge clk); guard++; end
    check("srst_reach_40", 32'(nbits_cnt), 32'd40);
    srst = 1'b1; data_in = data_b;
    @(negedge clk);
    check("srst_nbits", 32'(nbits_cnt), 32'd0);
    check("srst_done",  32'(scan_done), 32'd0);
    repeat (11) @(negedge clk);
    check("srst_gpio_clear", 32'(fp_gpio_out), 32'h000);
    release_srst();
    run_scan(data_b, "scanB");

    // Asynchronous reset while in LOAD
    fp_gpio_in = 12'hFFF; data_in = data_a;
    srst = 1'b1;
    repeat (2) @(negedge clk);
    release_srst();
    guard = 0;
    while (!fp_gpio_out[2] && guard < 8000) begin @(negedge clk); guard++; end
    check("load_seen", 32'(fp_gpio_out), 32'h404);
    check("load_gpio_in", 32'(gpio_in), 32'h022);
    #1 reset = 1'b0;
    #1;
    check("arst_gpio_out", 32'(fp_gpio_out), 32'h000);
    check("arst_gpio_in",  32'(gpio_in),     32'h000);
    check("arst_nbits",    32'(nbits_cnt),   32'd0);
    check("arst_done",     32'(scan_done),   32'd0);
    check("arst_scan_clk", 32'(scan_clk),    32'd0);
    check("arst_ddr",      32'(fp_gpio_ddr), 32'hD55);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_scan(data_a, "scanR");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hop_scan_io.md
Name: hop_scan_io

Overview:
- Drives the tag-chip hop-code scan chain and the front-panel GPIO.
- Divides the system clock into a scan tick, then shifts NTX_BITS of a hop code into the chip using a two-phase scan protocol (phi/phi_bar) and pulses load.
- Maps the scan signals, OR'd with user GPIO bits, onto a masked, rate-divided front-panel GPIO register.
- Sits between the hop-sequencing FSM (which supplies data_in and srst) and the FPGA pins.

Parameters:
- SCAN_CLK_DIV_FAC, 20: clk cycles per scan tick (even, ≥2).
- SCAN_WIDTH, 2: scan ticks per phi, phi_bar and load phase.
- NTX_BITS, 78: bits shifted per hop code.
- TX_BITS_WIDTH, 128: width of data_in.
- BIT_CNT_WIDTH, 7: width of nbits_cnt.
- GPIO_REG_WIDTH, 12: front-panel GPIO width.
- GPIO_CLK_DIV_FAC, 10: clk cycles per GPIO update.
- OUT_MASK, 12'hD55: GPIO bits driven.
- IN_MASK, 12'h022: GPIO bits sampled.
- IO_DDR, 12'hD55: direction register.

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-low reset
- srst  in  1  synchronous active-high restart of scan sequence
- data_in  in  TX_BITS_WIDTH  hop code; bits [NTX_BITS-1:0] used
- user_gpio_out  in  GPIO_REG_WIDTH  extra GPIO bits, OR'd with scan bits
- fp_gpio_in  in  GPIO_REG_WIDTH  pin inputs
- fp_gpio_out  out  GPIO_REG_WIDTH  pin outputs
- fp_gpio_ddr  out  GPIO_REG_WIDTH  pin direction (1=output)
- gpio_in  out  GPIO_REG_WIDTH  masked, sampled pin inputs
- scan_clk  out  1  divided clock, 50% duty, period SCAN_CLK_DIV_FAC
- nbits_cnt  out  BIT_CNT_WIDTH  bits fully shifted so far
- scan_done  out  1  high once load phase completes

Behaviour:
- Single clock domain. Divided clocks are strobes/toggles; no logic is clocked by scan_clk.
- Reset (reset=0), all outputs:
  - scan_clk=0, scan signals 0, nbits_cnt=0, scan_done=0.
  - fp_gpio_out=0, gpio_in=0.
  - fp_gpio_ddr=IO_DDR (constant, also during reset).
  - Dividers cleared; FSM in IDLE.
- Scan divider: counter 0..SCAN_CLK_DIV_FAC/2-1.
  - scan_clk toggles at terminal count.
  - scan_tick is a 1-cycle strobe coincident with the rising toggle.
  - The FSM advances only on scan_tick.
- FSM states:
  - IDLE: on tick, latch data_in[NTX_BITS-1:0] into shift reg, go to PHI.
  - PHI: scan_phi=1 for SCAN_WIDTH ticks, then PHI_BAR.
  - PHI_BAR: scan_phi_bar=1 for SCAN_WIDTH ticks, then shift reg left 1 and nbits_cnt++. Go to LOAD if nbits_cnt reaches NTX_BITS, else PHI.
  - LOAD: scan_load_chip=1 for SCAN_WIDTH ticks, then DONE.
  - DONE: scan_done=1; hold until srst/reset.
- Scan signal rules:
  - scan_data_in = shift reg MSB, so data_in[NTX_BITS-1] goes first; stable through PHI and PHI_BAR.
  - scan_id=1 in PHI, PHI_BAR and LOAD; 0 otherwise.
  - phi and phi_bar are never both high.
- Timing: IDLE to DONE takes 1 + NTX_BITS*2*SCAN_WIDTH + SCAN_WIDTH ticks (315 ticks = 6300 clk at defaults).
- srst at any state (including mid-shift): next cycle returns to IDLE, clears nbits_cnt/scan_done/scan signals, and preserves divider phase. srst and tick in the same cycle: srst wins.
- Scan-to-GPIO bit map: id→0x400, phi→0x100, phi_bar→0x040, data→0x010, load→0x004.
  - gpio_word = mapped bits | user_gpio_out.
- GPIO divider: strobe every GPIO_CLK_DIV_FAC clk. On strobe:
  - fp_gpio_out <= gpio_word & OUT_MASK.
  - gpio_in <= sync2(fp_gpio_in) & IN_MASK.
  - fp_gpio_in passes through a 2-flop synchronizer every clk.
- Latency: a scan signal change reaches fp_gpio_out on the next GPIO strobe (≤ GPIO_CLK_DIV_FAC cycles).
- nbits_cnt saturates at NTX_BITS. NTX_BITS must be ≤ TX_BITS_WIDTH and < 2^BIT_CNT_WIDTH.

Decomposition:
- Shared package: GPIO bit-map constants (SCAN_ID_BIT etc.), FSM state enum, default masks.
- One natural sub-module: clk_strobe_div (counter + toggle + strobe), instantiated twice (scan, GPIO).
- FSM and GPIO register stay in the top.

Test Plan:
- Reset: hold reset=0 → fp_gpio_out=0, gpio_in=0, fp_gpio_ddr=12'hD55, scan_done=0. Release → scan_clk period 20 clk, 50% duty.
- Full scan, data_in=78'h2A…A (alternating) → 78 phi/phi_bar pairs, each 2 ticks; data MSB-first matches pattern; nbits_cnt 0→78; load high 2 ticks; scan_done after 315 ticks.
- Non-overlap/ID: across whole sequence → phi&phi_bar never both 1; scan_id=1 exactly from first PHI to end of LOAD.
- srst mid-shift at nbits_cnt=40 → next cycle nbits_cnt=0, all scan bits 0; full 78-bit sequence restarts with newly latched data_in.
- GPIO mapping: user_gpio_out=12'hFFF during PHI → fp_gpio_out=12'hD55 (masked) updated only on 10-cycle strobes; fp_gpio_in=12'hFFF → gpio_in=12'h022 within 2 sync + ≤10 cycles.
- Async reset mid-LOAD → outputs clear immediately without clk edge; sequence restarts from IDLE after release.
